// File: rtl/rvm_ifu_pkg.sv
// Shared widths, cause codes and FSM encodings for the instruction fetch unit.
package rvm_ifu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned ST_W    = 2;
  localparam int unsigned TIMER_W = 8;

  localparam logic [CAUSE_W-1:0] CAUSE_OK       = 2'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_BUS      = 2'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = 2'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'd3;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_REQ   = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP  = 2'd2;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd3;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Response payload returned by instruction memory alongside rvalid.
  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] rdata;
  } imem_rsp_t;

  function automatic logic [XLEN-1:0] next_pc4(input logic [XLEN-1:0] addr);
    return addr + XLEN'(4);
  endfunction

endpackage

// File: rtl/rvm_ifu_if.sv
// Instruction-memory port: req/gnt request phase, rvalid response phase.
interface rvm_ifu_if;
  import rvm_ifu_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  imem_rsp_t       rsp;

  modport master (output req, addr, input gnt, rvalid, rsp);
  modport slave  (input req, addr, output gnt, rvalid, rsp);

endinterface

// File: rtl/rvm_ifu.sv
// Instruction fetch unit: one word per fetch_req over the imem port, latched for decode.
// Optional `RVM_IFU_MISALIGN_TRAP_EN reports misaligned pc as cause 3 instead of aligning it.
module rvm_ifu
  import rvm_ifu_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0] RESET_INSTR    = NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     pc,
  input  logic                fetch_req,
  input  logic                flush,
  output logic                fetch_done,
  output logic                fetch_error,
  output logic [CAUSE_W-1:0]  fetch_cause,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     instr_pc,
  output logic [XLEN-1:0]     pc_plus4,
  rvm_ifu_if.master           imem
);

  localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(TIMEOUT_CYCLES);

  logic [ST_W-1:0]    state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               imem_req_q, imem_req_d;
  logic [XLEN-1:0]    imem_addr_q, imem_addr_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [XLEN-1:0]    instr_q, instr_d;
  logic [XLEN-1:0]    instr_pc_q, instr_pc_d;
  logic [XLEN-1:0]    pc_plus4_q, pc_plus4_d;
  logic [TIMER_W-1:0] timer_inc;
  logic               timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cause_q     <= CAUSE_OK;
      instr_q     <= RESET_INSTR;
      instr_pc_q  <= '0;
      pc_plus4_q  <= XLEN'(4);
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cause_q     <= cause_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      pc_plus4_q  <= pc_plus4_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    cause_d     = cause_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pc_plus4_d  = pc_plus4_q;
    timer_inc   = timer_q + TIMER_W'(1);
    timeout_hit = (timer_inc == TIMEOUT_VAL);

    case (state_q)
      ST_IDLE: begin
        if (fetch_req && !flush) begin
`ifdef RVM_IFU_MISALIGN_TRAP_EN
          if (pc[1:0] != 2'b00) begin
            done_d     = 1'b1;
            error_d    = 1'b1;
            cause_d    = CAUSE_MISALIGN;
            instr_pc_d = pc;
            pc_plus4_d = next_pc4(pc);
          end else begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc;
            timer_d     = '0;
            state_d     = ST_REQ;
          end
`else
          imem_req_d  = 1'b1;
          imem_addr_d = pc & ~XLEN'(3);
          timer_d     = '0;
          state_d     = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        timer_d = timer_inc;
        if (flush) begin
          imem_req_d = 1'b0;
          state_d    = imem.gnt ? ST_DRAIN : ST_IDLE;
        end else if (timeout_hit) begin
          // A grant in the timeout cycle still owes us a response, so drain it.
          imem_req_d = 1'b0;
          done_d     = 1'b1;
          error_d    = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
          state_d    = imem.gnt ? ST_DRAIN : ST_IDLE;
        end else if (imem.gnt) begin
          imem_req_d = 1'b0;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        timer_d = timer_inc;
        if (flush) begin
          state_d = imem.rvalid ? ST_IDLE : ST_DRAIN;
        end else if (imem.rvalid) begin
          instr_d    = imem.rsp.rdata;
          instr_pc_d = imem_addr_q;
          pc_plus4_d = next_pc4(imem_addr_q);
          done_d     = 1'b1;
          error_d    = imem.rsp.err;
          cause_d    = imem.rsp.err ? CAUSE_BUS : CAUSE_OK;
          state_d    = ST_IDLE;
        end else if (timeout_hit) begin
          done_d  = 1'b1;
          error_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (imem.rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.req    = imem_req_q;
  assign imem.addr   = imem_addr_q;
  assign fetch_done  = done_q;
  assign fetch_error = error_q;
  assign fetch_cause = cause_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign pc_plus4    = pc_plus4_q;

endmodule
